// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: op-field positions, access sizes,
// error codes and FSM states.
package ysyx_22040237_lsu_pkg;

    localparam int OP_LOAD    = 0;
    localparam int OP_STORE   = 1;
    localparam int OP_SIZE_LO = 2;
    localparam int OP_UNS     = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Combinational byte-lane steering: store mask/data placement and load
// extraction with sign or zero extension.
module ysyx_22040237_lsu_align
    import ysyx_22040237_lsu_pkg::*;
(
    input  size_e       st_size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [7:0]  st_mask,
    output logic [63:0] st_wdata,
    input  size_e       ld_size,
    input  logic [2:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [63:0] ld_shift;

    always_comb begin
        st_mask = 8'hFF;
        case (st_size)
            SZ_B:    st_mask = 8'h01 << st_off;
            SZ_H:    st_mask = 8'h03 << st_off;
            SZ_W:    st_mask = 8'h0F << st_off;
            default: st_mask = 8'hFF;
        endcase
        st_wdata = st_data << {st_off, 3'b000};
    end

    always_comb begin
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        ld_data  = ld_shift;
        case (ld_size)
            SZ_B: ld_data = ld_unsigned ? {56'b0, ld_shift[7:0]}
                                        : {{56{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H: ld_data = ld_unsigned ? {48'b0, ld_shift[15:0]}
                                        : {{48{ld_shift[15]}}, ld_shift[15:0]};
            SZ_W: ld_data = ld_unsigned ? {32'b0, ld_shift[31:0]}
                                        : {{32{ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: accepts one memory op from execute, runs a req/gnt/rvalid
// bus transaction and returns extended load data to write-back.
module ysyx_22040237_lsu
    import ysyx_22040237_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int XLEN        = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [4:0]      lsu_op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            rd_wr_en_i,
    input  logic [4:0]      rd_idx_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wmask_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            resp_valid_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_idx_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [1:0]      err_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    state_e           state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    logic             ld_q;
    size_e            size_q;
    logic             uns_q;
    logic [2:0]       off_q;
    logic             rd_wr_en_q;
    logic [4:0]       rd_idx_q;

    logic             in_load;
    logic             in_store;
    size_e            in_size;
    logic             in_illegal;
    logic             in_misalign;
    logic [7:0]       st_mask;
    logic [63:0]      st_wdata;
    logic [63:0]      ld_data;

    assign in_load     = lsu_op_i[OP_LOAD];
    assign in_store    = lsu_op_i[OP_STORE];
    assign in_size     = size_e'(lsu_op_i[OP_SIZE_LO +: 2]);
    assign in_illegal  = (in_load == in_store);
    assign in_misalign = is_misaligned(in_size, addr_i[2:0]);

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM);

    // Store lanes come from the incoming op; load extraction from the latched op.
    ysyx_22040237_lsu_align u_align (
        .st_size     (in_size),
        .st_off      (addr_i[2:0]),
        .st_data     (wdata_i),
        .st_mask     (st_mask),
        .st_wdata    (st_wdata),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_rdata    (mem_rdata_i),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt_q        <= '0;
            req_ready_o  <= 1'b1;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_wmask_o  <= '0;
            resp_valid_o <= 1'b0;
            wb_en_o      <= 1'b0;
            wb_idx_o     <= '0;
            wb_data_o    <= '0;
            err_o        <= ERR_OK;
            ld_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= '0;
            rd_wr_en_q   <= 1'b0;
            rd_idx_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        ld_q        <= in_load;
                        size_q      <= in_size;
                        uns_q       <= lsu_op_i[OP_UNS];
                        off_q       <= addr_i[2:0];
                        rd_wr_en_q  <= rd_wr_en_i;
                        rd_idx_q    <= rd_idx_i;
                        req_ready_o <= 1'b0;
                        if (in_illegal || in_misalign) begin
                            state        <= S_RESP;
                            resp_valid_o <= 1'b1;
                            wb_en_o      <= 1'b0;
                            wb_idx_o     <= rd_idx_i;
                            wb_data_o    <= '0;
                            err_o        <= in_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        end else begin
                            state       <= S_REQ;
                            cnt_q       <= '0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= in_store;
                            mem_addr_o  <= {addr_i[XLEN-1:3], 3'b000};
                            mem_wdata_o <= in_store ? st_wdata : '0;
                            mem_wmask_o <= st_mask;
                        end
                    end
                end
                S_REQ: begin
                    // A response in the grant cycle is not legal on this bus and is dropped.
                    if (mem_gnt_i) begin
                        state     <= S_WAIT;
                        mem_req_o <= 1'b0;
                        cnt_q     <= '0;
                    end else if (timeout_hit) begin
                        state        <= S_RESP;
                        mem_req_o    <= 1'b0;
                        resp_valid_o <= 1'b1;
                        wb_en_o      <= 1'b0;
                        wb_idx_o     <= rd_idx_q;
                        wb_data_o    <= '0;
                        err_o        <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state        <= S_RESP;
                        resp_valid_o <= 1'b1;
                        wb_en_o      <= ld_q & rd_wr_en_q;
                        wb_idx_o     <= rd_idx_q;
                        wb_data_o    <= ld_q ? ld_data : '0;
                        err_o        <= ERR_OK;
                    end else if (timeout_hit) begin
                        state        <= S_RESP;
                        resp_valid_o <= 1'b1;
                        wb_en_o      <= 1'b0;
                        wb_idx_o     <= rd_idx_q;
                        wb_data_o    <= '0;
                        err_o        <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    wb_en_o      <= 1'b0;
                    wb_idx_o     <= '0;
                    wb_data_o    <= '0;
                    err_o        <= ERR_OK;
                end
            endcase
        end
    end

endmodule
